triangle_assembly: RTL and testbench
====================================

TRIANGLE_ASSEMBLY -- requirements
Module: triangle_assembly

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of assembled triangles buffered; power of two, at least 2.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port valid_in, input, 1 bit: a vertex is present this cycle. There is no backpressure to upstream.
REQ-005 SHALL have port position_in, input, [2:0][31:0]: vertex x/y/z.
REQ-006 SHALL have port normal_in, input, 12 bits: vertex normal index.
REQ-007 SHALL have port material_in, input, 12 bits: vertex material index.
REQ-008 SHALL have port ready_in, input, 1 bit: downstream accepts the triangle.
REQ-009 SHALL have port valid_out, output, 1 bit: a triangle is presented.
REQ-010 SHALL have port triangle_out, output, [2:0][2:0][31:0]: vertices 0/1/2 in arrival order.
REQ-011 SHALL have port normal_out, output, 12 bits: normal index of vertex 0 (the provoking vertex).
REQ-012 SHALL have port material_out, output, 12 bits: material index of vertex 0.
REQ-013 SHALL have port triangle_id_out, output, 12 bits: sequence number of the presented triangle.
REQ-014 SHALL have port overflow_out, output, 1 bit: sticky flag, set when a triangle was lost to a full FIFO.

Function
REQ-015 SHALL count accepted vertices with a slot counter 0->1->2->0, advancing only on valid_in, and SHALL hold the counter when valid_in is low, so gaps between vertices are allowed.
REQ-016 SHALL latch position_in into the current slot; in slot 0 it SHALL also latch normal_in and material_in.
REQ-017 SHALL, on the cycle slot 2 accepts a vertex, form the triangle from slots 0/1 and the live slot-2 input, and push it into the FIFO at that clock edge.
REQ-018 SHALL assign each formed triangle an id from a 12-bit counter that starts at 0, increments per formed triangle (including dropped or culled triangles) and wraps 12'hFFF->0.
REQ-019 SHALL give the FIFO a latency of 1: with the FIFO empty and the third vertex accepted in cycle N, valid_out SHALL be high in cycle N+1.
REQ-020 SHALL implement the output handshake as follows: transfer occurs when valid_out && ready_in; while valid_out is high and ready_in is low, all outputs SHALL hold stable.
REQ-021 SHALL, when the FIFO is full at push time with no pop, drop the new triangle, set overflow_out, and leave the FIFO contents unchanged.
REQ-022 SHALL, on simultaneous push and pop with the FIFO full, perform both, so that no drop occurs and occupancy is unchanged.
REQ-023 SHALL, on simultaneous push and pop with the FIFO empty, present the pushed triangle in the next cycle.
REQ-024 SHALL keep overflow_out high until reset once it is set.
REQ-025 SHALL drive triangle_out, normal_out, material_out and triangle_id_out as don't-care when valid_out is low; the bench SHALL NOT check them then.

Reset
REQ-026 SHALL, with rst_in high at a clock edge, clear the slot counter, the id counter, FIFO occupancy, valid_out and overflow_out to 0.
REQ-027 SHALL discard a partially assembled triangle on reset mid-triangle; the first vertex after reset is slot 0.
REQ-028 SHALL drive all data outputs to 0 after reset.
REQ-029 SHALL give rst_in priority over valid_in and ready_in in the same cycle.

Configuration
REQ-030 SHALL, with macro TRIANGLE_DEGENERATE_CULL_EN defined, not push a formed triangle whose vertices have any two positions bitwise equal; such a triangle still consumes an id.
REQ-031 SHALL, without TRIANGLE_DEGENERATE_CULL_EN, push every formed triangle regardless of its positions.

Verification
REQ-032 SHALL cover this scenario: ready_in=1 and 3 consecutive vertices with positions {1,2,3},{4,5,6},{7,8,9}, normal 5 then 6,7, material 9 -> valid_out high exactly 1 cycle after the third vertex, triangle in order, normal_out=5, material_out=9, id 0.
REQ-033 SHALL cover this scenario: vertices with 2-cycle gaps and ready_in=1 -> identical triangle to the previous scenario, emitted 1 cycle after the third vertex.
REQ-034 SHALL cover this scenario: ready_in=0 and 5 triangles with FIFO_DEPTH=4 -> 4 triangles buffered, overflow_out=1; then ready_in=1 -> ids 0,1,2,3 drained in order, id 4 never appears.
REQ-035 SHALL cover this scenario: reset asserted after 2 vertices, then 3 new vertices A,B,C -> triangle is exactly A,B,C with id 0.
REQ-036 SHALL cover this scenario: FIFO full, ready_in=1 in the same cycle as the third vertex -> no overflow, occupancy stays 4.
REQ-037 SHALL cover this scenario: with TRIANGLE_DEGENERATE_CULL_EN, triangle with v0==v2 followed by a valid triangle -> only the second is emitted, with id 1; without the macro both are emitted, with ids 0 and 1.

Source files
------------

// File: rtl/triangle_assembly.sv
// Triangle assembly: groups vertex triples into triangles and buffers them in a small FIFO.
// Optional build macro TRIANGLE_DEGENERATE_CULL_EN drops triangles with coincident vertices.
module triangle_assembly #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    input  logic [2:0][31:0]      position_in,
    input  logic [11:0]           normal_in,
    input  logic [11:0]           material_in,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [2:0][2:0][31:0] triangle_out,
    output logic [11:0]           normal_out,
    output logic [11:0]           material_out,
    output logic [11:0]           triangle_id_out,
    output logic                  overflow_out
);

    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned IDW = 12;

    typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2} slot_e;

    slot_e            slot_q, slot_d;
    logic [2:0][31:0] v0_q, v0_d, v1_q, v1_d;
    logic [11:0]      nrm_q, nrm_d, mat_q, mat_d;
    logic [IDW-1:0]   id_q;
    logic             form_c;

    logic [2:0][2:0][31:0] tri_c;
    logic                  push_c, pop_c, wr_c, drop_c, full_c, empty_c;

    logic [2:0][2:0][31:0] tri_mem_q [FIFO_DEPTH];
    logic [11:0]           nrm_mem_q [FIFO_DEPTH];
    logic [11:0]           mat_mem_q [FIFO_DEPTH];
    logic [IDW-1:0]        id_mem_q  [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q;

    // Slot sequencing: latch vertices 0/1, flag formation when vertex 2 arrives.
    always_comb begin
        slot_d = slot_q;
        v0_d   = v0_q;
        v1_d   = v1_q;
        nrm_d  = nrm_q;
        mat_d  = mat_q;
        form_c = 1'b0;
        if (valid_in) begin
            case (slot_q)
                SLOT0: begin
                    slot_d = SLOT1;
                    v0_d   = position_in;
                    nrm_d  = normal_in;
                    mat_d  = material_in;
                end
                SLOT1: begin
                    slot_d = SLOT2;
                    v1_d   = position_in;
                end
                SLOT2: begin
                    slot_d = SLOT0;
                    form_c = 1'b1;
                end
                default: slot_d = SLOT0;
            endcase
        end
    end

    always_comb begin
        tri_c[0] = v0_q;
        tri_c[1] = v1_q;
        tri_c[2] = position_in;
`ifdef TRIANGLE_DEGENERATE_CULL_EN
        push_c = form_c && (v0_q != v1_q) && (v1_q != position_in) && (v0_q != position_in);
`else
        push_c = form_c;
`endif
    end

    // FIFO control: a pop frees the head slot so a push into a full FIFO still succeeds.
    always_comb begin
        empty_c = (count_q == '0);
        full_c  = (count_q == CW'(FIFO_DEPTH));
        pop_c   = !empty_c && ready_in;
        wr_c    = push_c && (!full_c || pop_c);
        drop_c  = push_c && full_c && !pop_c;
        count_d = count_q;
        case ({wr_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_q   <= SLOT0;
            v0_q     <= '0;
            v1_q     <= '0;
            nrm_q    <= '0;
            mat_q    <= '0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            nrm_q   <= nrm_d;
            mat_q   <= mat_d;
            count_q <= count_d;
            ovf_q   <= ovf_q | drop_c;
            if (form_c) id_q     <= id_q + IDW'(1);
            if (wr_c)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage carries no reset; the read side is masked to zero while empty.
    always_ff @(posedge clk_in) begin
        if (!rst_in && wr_c) begin
            tri_mem_q[wr_ptr_q] <= tri_c;
            nrm_mem_q[wr_ptr_q] <= nrm_q;
            mat_mem_q[wr_ptr_q] <= mat_q;
            id_mem_q[wr_ptr_q]  <= id_q;
        end
    end

    assign valid_out       = !empty_c;
    assign overflow_out    = ovf_q;
    assign triangle_out    = empty_c ? '0 : tri_mem_q[rd_ptr_q];
    assign normal_out      = empty_c ? '0 : nrm_mem_q[rd_ptr_q];
    assign material_out    = empty_c ? '0 : mat_mem_q[rd_ptr_q];
    assign triangle_id_out = empty_c ? '0 : id_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_triangle_assembly.sv
// Self-checking bench for triangle_assembly: directed scenarios plus randomized traffic
// compared against a queue-based model of vertex grouping and triangle buffering.
module tb_triangle_assembly;

    localparam int unsigned DEPTH = 4;

    typedef logic [2:0][31:0] pos_t;
    typedef struct packed {
        logic [2:0][2:0][31:0] tv;
        logic [11:0]           nrm;
        logic [11:0]           mat;
        logic [11:0]           id;
    } tri_t;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b0;
    logic                  valid_in = 1'b0;
    pos_t                  position_in = '0;
    logic [11:0]           normal_in = '0;
    logic [11:0]           material_in = '0;
    logic                  ready_in = 1'b0;
    logic                  valid_out;
    logic [2:0][2:0][31:0] triangle_out;
    logic [11:0]           normal_out;
    logic [11:0]           material_out;
    logic [11:0]           triangle_id_out;
    logic                  overflow_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    tri_t        m_q[$];
    pos_t        m_verts[$];
    logic [11:0] m_nrm, m_mat;
    int          m_id = 0;
    bit          m_ovf = 1'b0;

    triangle_assembly #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
        .position_in(position_in), .normal_in(normal_in), .material_in(material_in),
        .ready_in(ready_in), .valid_out(valid_out), .triangle_out(triangle_out),
        .normal_out(normal_out), .material_out(material_out),
        .triangle_id_out(triangle_id_out), .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic pos_t mk(input int a, input int b, input int c);
        pos_t p;
        p[0] = 32'(a);
        p[1] = 32'(b);
        p[2] = 32'(c);
        return p;
    endfunction

    // Advance one clock, updating the model from the inputs applied before the edge.
    task automatic tick();
        tri_t t;
        bit   pop, push, degen;
        push = 1'b0;
        t = '0;
        if (rst_in) begin
            m_q.delete();
            m_verts.delete();
            m_id  = 0;
            m_ovf = 1'b0;
        end else begin
            pop = (m_q.size() != 0) && ready_in;
            if (valid_in) begin
                if (m_verts.size() == 0) begin
                    m_nrm = normal_in;
                    m_mat = material_in;
                end
                m_verts.push_back(position_in);
                if (m_verts.size() == 3) begin
                    t.tv  = {m_verts[2], m_verts[1], m_verts[0]};
                    t.nrm = m_nrm;
                    t.mat = m_mat;
                    t.id  = 12'(m_id);
                    m_id  = (m_id + 1) % 4096;
`ifdef TRIANGLE_DEGENERATE_CULL_EN
                    degen = (m_verts[0] == m_verts[1]) || (m_verts[1] == m_verts[2]) ||
                            (m_verts[0] == m_verts[2]);
`else
                    degen = 1'b0;
`endif
                    if (!degen) begin
                        if (m_q.size() < DEPTH || pop) push = 1'b1;
                        else m_ovf = 1'b1;
                    end
                    m_verts.delete();
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(t);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input pos_t p, input logic [11:0] n, input logic [11:0] m);
        valid_in    = 1'b1;
        position_in = p;
        normal_in   = n;
        material_in = m;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        valid_in = 1'b1;
        ready_in = 1'b1;
        position_in = mk(1, 1, 1);
        tick();
        tick();
        rst_in   = 1'b0;
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || overflow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b ovf=%b required 0 0", valid_out, overflow_out);
        end
        checks++;
        if (triangle_out !== '0 || normal_out !== '0 || material_out !== '0 || triangle_id_out !== '0) begin
            errors++;
            $display("FAIL reset_data: id=%h nrm=%h mat=%h required all zero", triangle_id_out, normal_out, material_out);
        end
    endtask

    task automatic test_basic();
        do_reset();
        ready_in = 1'b1;
        send(mk(1, 2, 3), 12'd5, 12'd9);
        send(mk(4, 5, 6), 12'd6, 12'd9);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: valid=%b required 0", valid_out);
        end
        send(mk(7, 8, 9), 12'd7, 12'd9);
        checks++;
        if (valid_out !== 1'b1 || triangle_out[0] !== mk(1, 2, 3) || triangle_out[1] !== mk(4, 5, 6) ||
            triangle_out[2] !== mk(7, 8, 9)) begin
            errors++;
            $display("FAIL basic_tri: valid=%b tri=%h", valid_out, triangle_out);
        end
        checks++;
        if (normal_out !== 12'd5 || material_out !== 12'd9 || triangle_id_out !== 12'd0) begin
            errors++;
            $display("FAIL basic_attr: nrm=%0d mat=%0d id=%0d required 5 9 0", normal_out, material_out, triangle_id_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: valid=%b required 0", valid_out);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        ready_in = 1'b1;
        send(mk(1, 2, 3), 12'd5, 12'd9);
        tick(); tick();
        send(mk(4, 5, 6), 12'd6, 12'd9);
        tick(); tick();
        send(mk(7, 8, 9), 12'd7, 12'd9);
        checks++;
        if (valid_out !== 1'b1 || triangle_out[0] !== mk(1, 2, 3) || triangle_out[1] !== mk(4, 5, 6) ||
            triangle_out[2] !== mk(7, 8, 9) || normal_out !== 12'd5 || material_out !== 12'd9 ||
            triangle_id_out !== 12'd0) begin
            errors++;
            $display("FAIL gaps_tri: valid=%b id=%0d nrm=%0d mat=%0d required 1 0 5 9", valid_out,
                     triangle_id_out, normal_out, material_out);
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        ready_in = 1'b0;
        for (int t = 0; t < 5; t++)
            for (int k = 0; k < 3; k++)
                send(mk(t * 10 + k, k, t), 12'(t), 12'(t + 100));
        checks++;
        if (valid_out !== 1'b1 || overflow_out !== 1'b1 || triangle_id_out !== 12'd0) begin
            errors++;
            $display("FAIL ovf_flag: valid=%b ovf=%b id=%0d required 1 1 0", valid_out, overflow_out, triangle_id_out);
        end
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_out !== 1'b1 || triangle_id_out !== 12'(i) || normal_out !== 12'(i)) begin
                errors++;
                $display("FAIL ovf_drain: valid=%b id=%0d required 1 %0d", valid_out, triangle_id_out, i);
            end
            tick();
        end
        checks++;
        if (valid_out !== 1'b0 || overflow_out !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty: valid=%b ovf=%b required 0 1", valid_out, overflow_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_in = 1'b1;
        send(mk(50, 51, 52), 12'd1, 12'd2);
        send(mk(60, 61, 62), 12'd1, 12'd2);
        do_reset();
        send(mk(11, 12, 13), 12'd33, 12'd44);
        send(mk(21, 22, 23), 12'd34, 12'd45);
        send(mk(31, 32, 33), 12'd35, 12'd46);
        checks++;
        if (valid_out !== 1'b1 || triangle_out[0] !== mk(11, 12, 13) || triangle_out[1] !== mk(21, 22, 23) ||
            triangle_out[2] !== mk(31, 32, 33) || triangle_id_out !== 12'd0 || normal_out !== 12'd33 ||
            material_out !== 12'd44) begin
            errors++;
            $display("FAIL reset_mid: valid=%b id=%0d nrm=%0d tri=%h", valid_out, triangle_id_out, normal_out, triangle_out);
        end
        tick();
    endtask

    task automatic test_full_push_pop();
        do_reset();
        ready_in = 1'b0;
        for (int t = 0; t < 4; t++)
            for (int k = 0; k < 3; k++)
                send(mk(t, k, 7), 12'd0, 12'd0);
        send(mk(9, 0, 1), 12'd0, 12'd0);
        send(mk(9, 1, 1), 12'd0, 12'd0);
        ready_in = 1'b1;
        send(mk(9, 2, 1), 12'd0, 12'd0);
        checks++;
        if (overflow_out !== 1'b0 || valid_out !== 1'b1 || triangle_id_out !== 12'd1) begin
            errors++;
            $display("FAIL fullpp_head: ovf=%b valid=%b id=%0d required 0 1 1", overflow_out, valid_out, triangle_id_out);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (valid_out !== 1'b1 || triangle_id_out !== 12'(i)) begin
                errors++;
                $display("FAIL fullpp_drain: valid=%b id=%0d required 1 %0d", valid_out, triangle_id_out, i);
            end
            tick();
        end
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_occupancy: valid=%b required 0 after 4 pops", valid_out);
        end
    endtask

    task automatic test_cull();
        do_reset();
        ready_in = 1'b0;
        send(mk(1, 1, 1), 12'd1, 12'd1);
        send(mk(2, 2, 2), 12'd1, 12'd1);
        send(mk(1, 1, 1), 12'd1, 12'd1);
        send(mk(3, 0, 0), 12'd2, 12'd2);
        send(mk(0, 3, 0), 12'd2, 12'd2);
        send(mk(0, 0, 3), 12'd2, 12'd2);
        ready_in = 1'b1;
`ifdef TRIANGLE_DEGENERATE_CULL_EN
        checks++;
        if (valid_out !== 1'b1 || triangle_id_out !== 12'd1 || normal_out !== 12'd2) begin
            errors++;
            $display("FAIL cull_first: valid=%b id=%0d required 1 1", valid_out, triangle_id_out);
        end
`else
        checks++;
        if (valid_out !== 1'b1 || triangle_id_out !== 12'd0 || normal_out !== 12'd1) begin
            errors++;
            $display("FAIL cull_first: valid=%b id=%0d required 1 0", valid_out, triangle_id_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || triangle_id_out !== 12'd1) begin
            errors++;
            $display("FAIL cull_second: valid=%b id=%0d required 1 1", valid_out, triangle_id_out);
        end
`endif
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL cull_empty: valid=%b required 0", valid_out);
        end
    endtask

    task automatic test_random();
        pos_t p;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            ready_in = ($urandom_range(0, 99) < 45);
            valid_in = ($urandom_range(0, 99) < 75);
            for (int k = 0; k < 3; k++)
                p[k] = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 2)) : $urandom;
            position_in = p;
            normal_in   = 12'($urandom);
            material_in = 12'($urandom);
            tick();
            checks++;
            if (valid_out !== (m_q.size() != 0) || overflow_out !== m_ovf) begin
                errors++;
                $display("FAIL rand_flags cyc %0d: valid=%b ovf=%b required %b %b", c, valid_out,
                         overflow_out, m_q.size() != 0, m_ovf);
            end else if (m_q.size() != 0) begin
                checks++;
                if (triangle_out !== m_q[0].tv || normal_out !== m_q[0].nrm ||
                    material_out !== m_q[0].mat || triangle_id_out !== m_q[0].id) begin
                    errors++;
                    $display("FAIL rand_data cyc %0d: id=%0d nrm=%h mat=%h required id=%0d nrm=%h mat=%h", c,
                             triangle_id_out, normal_out, material_out, m_q[0].id, m_q[0].nrm, m_q[0].mat);
                end
            end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_reset_mid();
        test_full_push_pop();
        test_cull();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
